spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
SPI slave front end that deserialises MOSI frames into 10-bit command/data words for the downstream single-port RAM, which is driven via rx_data/rx_valid. It also serialises the RAM's read word, received on tx_data/tx_valid, onto MISO. A single system clock serves as the SPI bit clock: one bit is transferred per rising edge while ss_n is low. Frame format is MSB first: {cmd[1:0], payload[7:0]}.

Parameters:
DATA_WIDTH, 8, payload/RAM word width; frame width = DATA_WIDTH+2

Ports:
clk  input  1  system clock, also the SPI bit clock; all logic on rising edge
a_rst_n  input  1  asynchronous active-low reset
ss_n  input  1  slave select, active low; high aborts/ends the transaction
mosi  input  1  serial data in, sampled on rising clk
miso  output  1  serial data out, registered
rx_data  output  DATA_WIDTH+2  assembled frame to RAM din; holds last complete frame
rx_valid  output  1  one-cycle pulse: rx_data holds a new complete frame
tx_data  input  DATA_WIDTH  read word from RAM dout
tx_valid  input  1  RAM read-data valid

Behaviour:
- Reset (async, a_rst_n=0):
  - state=IDLE; rx_data=0, rx_valid=0, miso=0.
  - bit counter=0, rd_addr_flag=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: on an edge with ss_n=0 -> CHK_CMD; otherwise stay.
- CHK_CMD:
  - If ss_n=1 -> IDLE.
  - Otherwise sample mosi as frame bit 9. If it is 0 -> WRITE; if 1 -> READ_ADD when rd_addr_flag=0, else READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Sample bits 8..0 on the next 9 edges (counter 0..8), shifting into the frame register.
  - On the edge that samples bit 0: rx_data <= full frame; rx_valid=1 for exactly the following cycle.
  - Total latency from the CHK_CMD edge to rx_valid high: 10 clk edges.
  - Frame contents are forwarded unmodified; the RAM decodes rx_data[9:8].
  - Bits arriving after frame completion in WRITE/READ_ADD are ignored. Stay in state until ss_n=1, then -> IDLE.
- rd_addr_flag:
  - Set on frame completion in READ_ADD.
  - Cleared when the READ_DATA transmit completes, and by reset.
  - Not cleared by an ss_n abort.
- READ_DATA transmit phase:
  - After frame completion, wait for tx_valid=1. tx_valid is ignored before completion.
  - First edge with tx_valid=1: load tx shift register with tx_data.
  - miso presents tx_data[7] in the next cycle, then one bit per edge MSB first, for DATA_WIDTH cycles.
  - After the last bit: miso=0, rd_addr_flag=0; stay until ss_n=1, then -> IDLE.
  - Later tx_valid pulses in the same transaction are ignored.
  - No timeout: wait for tx_valid indefinitely while ss_n=0.
- miso=0 in every state/cycle other than the transmit window.
- ss_n=1 at any edge in any non-IDLE state:
  - -> IDLE on that edge; counter cleared; partial frame discarded.
  - No rx_valid pulse; rx_data keeps its previous value; miso=0 from the next cycle.
- ss_n=1 on the same edge as the last receive bit: abort wins; no rx_valid.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.
- Width rules:
  - Counter is $clog2(DATA_WIDTH+2) bits.
  - Receive compare uses DATA_WIDTH; transmit compare uses DATA_WIDTH-1.
  - No overflow: the counter saturates at the terminal value until IDLE.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum, one-hot or binary, 3 bits: IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - FRAME_WIDTH function of DATA_WIDTH
- One optional sub-module, spi_tx_serializer: load/shift register plus count, outputs miso and a done pulse. FSM and receive shifter stay in the top module.

Test Plan:
- Write address: ss_n=0, shift 00_0011_1010 -> single rx_valid pulse 10 edges after the CHK_CMD edge, rx_data=10'h03A; miso stays 0.
- Write data: shift 01_1100_0101 -> rx_data=10'h1C5, one rx_valid; then ss_n=1 -> IDLE.
- Read address then read data:
  - Shift 10_0011_1010 -> rx_data=10'h23A, rd_addr_flag=1.
  - New transaction: shift 11_0000_0000 -> rx_data=10'h300.
  - Model tx_valid=1 with tx_data=8'hC5 one cycle after rx_valid -> miso sequence 1,1,0,0,0,1,0,1 starting the cycle after tx_valid; afterwards rd_addr_flag=0.
- Abort: ss_n=1 after 5 WRITE bits -> IDLE next edge, no rx_valid, rx_data unchanged; next full frame 00_1111_1111 -> rx_data=10'h0FF.
- Read-data ordering: frame starting with 1 while rd_addr_flag=0 -> treated as READ_ADD, sets flag, no MISO output; a tx_valid pulse during a READ_DATA receive is ignored.
- Reset mid-transmit: assert a_rst_n=0 after 3 miso bits -> miso=0, rx_valid=0, rd_addr_flag=0, state IDLE immediately; a subsequent write frame works normally.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // A frame is the 2-bit command followed by one RAM word.
    function automatic int unsigned frame_width(input int unsigned data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first shifter driving the registered MISO line.
module spi_tx_serializer
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  miso,
    output logic                  done
);

    localparam int unsigned CW = $clog2(frame_width(DATA_WIDTH));
    localparam logic [CW-1:0] TX_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            miso      <= 1'b0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            miso      <= 1'b0;
        end else if (load) begin
            // MSB goes straight to the line; the register holds the remainder.
            miso      <= data[DATA_WIDTH-1];
            shift_reg <= data << 1;
            bit_cnt   <= '0;
            active    <= 1'b1;
        end else if (active) begin
            if (bit_cnt == TX_LAST) begin
                miso   <= 1'b0;
                active <= 1'b0;
            end else begin
                miso      <= shift_reg[DATA_WIDTH-1];
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt + CW'(1);
            end
        end
    end

    assign done = active && (bit_cnt == TX_LAST);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises command frames toward the RAM and serialises
// the RAM read word back onto MISO.
module spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 8,
    localparam int unsigned FRAME_WIDTH = frame_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   a_rst_n,
    input  logic                   ss_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_valid
);

    localparam int unsigned CW = $clog2(FRAME_WIDTH);
    localparam logic [CW-1:0] RX_LAST = CW'(DATA_WIDTH);

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          bit_cnt;
    logic [FRAME_WIDTH-1:0] shift_reg;
    logic                   rx_done;
    logic                   rd_addr_flag;
    logic                   tx_started;
    logic                   tx_load;
    logic                   tx_clear;
    logic                   tx_done;
    logic                   receiving;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!ss_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (ss_n) begin
                    next_state = IDLE;
                end else if (mosi != CMD_RD_ADDR[1]) begin
                    next_state = WRITE;
                end else if (!rd_addr_flag) begin
                    next_state = READ_ADD;
                end else begin
                    next_state = READ_DATA;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (ss_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign receiving = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // Read word is only accepted once the READ_DATA frame is complete, and once per transaction.
    assign tx_load  = (state == READ_DATA) && rx_done && !tx_started && tx_valid && !ss_n;
    assign tx_clear = ss_n || (state != READ_DATA);

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_done      <= 1'b0;
            rd_addr_flag <= 1'b0;
            tx_started   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_n || state == IDLE) begin
                bit_cnt    <= '0;
                shift_reg  <= '0;
                rx_done    <= 1'b0;
                tx_started <= 1'b0;
            end else if (state == CHK_CMD) begin
                shift_reg <= {shift_reg[FRAME_WIDTH-2:0], mosi};
                bit_cnt   <= '0;
                rx_done   <= 1'b0;
            end else if (receiving) begin
                if (!rx_done) begin
                    shift_reg <= {shift_reg[FRAME_WIDTH-2:0], mosi};
                    if (bit_cnt == RX_LAST) begin
                        // Counter stays at RX_LAST; rx_done blocks further sampling.
                        rx_data  <= {shift_reg[FRAME_WIDTH-2:0], mosi};
                        rx_valid <= 1'b1;
                        rx_done  <= 1'b1;
                        if (state == READ_ADD) rd_addr_flag <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                if (tx_load) tx_started   <= 1'b1;
                if (tx_done) rd_addr_flag <= 1'b0;
            end
        end
    end

    spi_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx (
        .clk  (clk),
        .rst_n(a_rst_n),
        .clear(tx_clear),
        .load (tx_load),
        .data (tx_data),
        .miso (miso),
        .done (tx_done)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: expected frames/MISO bits are queued
// as stimulus is driven and compared against what the DUT produces.
`timescale 1ns/100ps
module tb_spi_slave_if;
    import spi_slave_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned FW = DW + 2;

    logic          clk = 1'b0;
    logic          a_rst_n = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned stray_miso = 0;
    logic        tx_window = 1'b0;
    logic [FW-1:0] last_rx = '0;

    logic [FW-1:0] exp_rx_q[$];
    logic [FW-1:0] obs_rx_q[$];
    logic          exp_miso_q[$];

    spi_slave_if #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    // Monitor samples 1ns after each rising edge; stimulus moves at 2ns.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) obs_rx_q.push_back(rx_data);
        if (miso !== 1'b0 && !tx_window) stray_miso++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drives one transaction; abort_at raises ss_n on the edge that would sample that bit.
    task automatic send_frame(input logic [FW-1:0] f, input int pulse_at, input int abort_at);
        logic aborted;
        aborted = 1'b0;
        ss_n = 1'b0;
        tick();
        for (int i = FW - 1; i >= 0; i--) begin
            mosi = f[i];
            tx_valid = (i == pulse_at);
            if (i == abort_at) begin
                ss_n = 1'b1;
                aborted = 1'b1;
            end
            tick();
            if (aborted) break;
        end
        tx_valid = 1'b0;
        mosi = 1'b0;
        if (!aborted) begin
            exp_rx_q.push_back(f);
            last_rx = f;
        end
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) exp_miso_q.push_back(w[i]);
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        ss_n = 1'b1;
        #3;
        vectors++;
        if (rx_valid !== 1'b0 || miso !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: rx_valid=%b miso=%b, expected 0 0", rx_valid, miso);
        end
        vectors++;
        if (rx_data !== '0) begin
            miscompares++;
            $display("FAIL reset_rx_data: got %h, expected 000", rx_data);
        end
        vectors++;
        if (dut.state !== IDLE || dut.rd_addr_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d flag=%b, expected 0 0", dut.state, dut.rd_addr_flag);
        end
        tick();
        tick();
        a_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_addr();
        logic [FW-1:0] e, o;
        send_frame(10'h03A, -1, -1);
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== 10'h03A) begin
            miscompares++;
            $display("FAIL wa_latency: rx_valid=%b rx_data=%h, expected 1 03a", rx_valid, rx_data);
        end
        tick();
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wa_pulse_width: rx_valid=%b, expected 0", rx_valid);
        end
        ss_n = 1'b1;
        tick();
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL wa_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wa_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
    endtask

    task automatic test_write_data();
        logic [FW-1:0] e, o;
        send_frame(10'h1C5, -1, -1);
        // trailing bits after completion must be ignored
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom_range(0, 1));
            tick();
        end
        ss_n = 1'b1;
        tick();
        vectors++;
        if (dut.state !== IDLE) begin
            miscompares++;
            $display("FAIL wd_idle: state=%0d, expected 0", dut.state);
        end
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL wd_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wd_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
        vectors++;
        if (stray_miso != 0) begin
            miscompares++;
            $display("FAIL wd_miso_quiet: %0d high cycles, expected 0", stray_miso);
        end
    endtask

    task automatic test_read_sequence();
        logic [FW-1:0] e, o;
        logic b;
        send_frame(10'h23A, -1, -1);
        ss_n = 1'b1;
        tick();
        vectors++;
        if (dut.rd_addr_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL rs_flag_set: got %b, expected 1", dut.rd_addr_flag);
        end
        send_frame(10'h300, -1, -1);
        tick();
        tx_valid = 1'b1;
        tx_data = 8'hC5;
        push_tx(8'hC5);
        tx_window = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data = 8'h00;
        for (int i = 0; i < int'(DW); i++) begin
            b = exp_miso_q.pop_front();
            vectors++;
            if (miso !== b) begin
                miscompares++;
                $display("FAIL rs_miso_bit%0d: got %b, expected %b", i, miso, b);
            end
            tick();
        end
        tx_window = 1'b0;
        vectors++;
        if (miso !== 1'b0 || dut.rd_addr_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL rs_tx_end: miso=%b flag=%b, expected 0 0", miso, dut.rd_addr_flag);
        end
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        repeat (4) tick();
        ss_n = 1'b1;
        tick();
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL rs_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rs_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
        vectors++;
        if (stray_miso != 0) begin
            miscompares++;
            $display("FAIL rs_miso_quiet: %0d high cycles, expected 0", stray_miso);
        end
    endtask

    task automatic test_abort();
        logic [FW-1:0] e, o;
        logic [FW-1:0] held;
        held = last_rx;
        send_frame(10'h0AA, -1, 3);
        vectors++;
        if (dut.state !== IDLE) begin
            miscompares++;
            $display("FAIL ab_idle: state=%0d, expected 0", dut.state);
        end
        repeat (3) tick();
        vectors++;
        if (obs_rx_q.size() != 0 || rx_data !== held) begin
            miscompares++;
            $display("FAIL ab_no_frame: pulses=%0d rx_data=%h, expected 0 %h", obs_rx_q.size(), rx_data, held);
        end
        send_frame(10'h0FF, -1, -1);
        ss_n = 1'b1;
        tick();
        held = last_rx;
        send_frame(10'h155, -1, 0);
        repeat (2) tick();
        vectors++;
        if (dut.state !== IDLE || rx_data !== held) begin
            miscompares++;
            $display("FAIL ab_last_bit: state=%0d rx_data=%h, expected 0 %h", dut.state, rx_data, held);
        end
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL ab_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ab_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
    endtask

    task automatic test_read_ordering();
        logic [FW-1:0] e, o;
        logic b;
        send_frame(10'h3AB, -1, -1);
        vectors++;
        if (dut.state !== READ_ADD || dut.rd_addr_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL ro_read_add: state=%0d flag=%b, expected 3 1", dut.state, dut.rd_addr_flag);
        end
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        repeat (3) tick();
        ss_n = 1'b1;
        tick();
        send_frame(10'h3F0, 4, -1);
        repeat (3) tick();
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        push_tx(8'h5A);
        tx_window = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            b = exp_miso_q.pop_front();
            vectors++;
            if (miso !== b) begin
                miscompares++;
                $display("FAIL ro_miso_bit%0d: got %b, expected %b", i, miso, b);
            end
            tick();
        end
        tx_window = 1'b0;
        ss_n = 1'b1;
        tick();
        vectors++;
        if (dut.rd_addr_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL ro_flag_clear: got %b, expected 0", dut.rd_addr_flag);
        end
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL ro_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ro_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
        vectors++;
        if (stray_miso != 0) begin
            miscompares++;
            $display("FAIL ro_miso_quiet: %0d high cycles, expected 0", stray_miso);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [FW-1:0] e, o;
        logic b;
        send_frame(10'h2C1, -1, -1);
        ss_n = 1'b1;
        tick();
        send_frame(10'h301, -1, -1);
        tick();
        tx_valid = 1'b1;
        tx_data = 8'hB7;
        push_tx(8'hB7);
        tx_window = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = exp_miso_q.pop_front();
            vectors++;
            if (miso !== b) begin
                miscompares++;
                $display("FAIL rm_miso_bit%0d: got %b, expected %b", i, miso, b);
            end
            tick();
        end
        #1;
        a_rst_n = 1'b0;
        #1;
        vectors++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0) begin
            miscompares++;
            $display("FAIL rm_outputs: miso=%b rx_valid=%b rx_data=%h, expected 0 0 000", miso, rx_valid, rx_data);
        end
        vectors++;
        if (dut.state !== IDLE || dut.rd_addr_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_state: state=%0d flag=%b, expected 0 0", dut.state, dut.rd_addr_flag);
        end
        exp_miso_q.delete();
        tx_window = 1'b0;
        ss_n = 1'b1;
        tick();
        tick();
        a_rst_n = 1'b1;
        tick();
        send_frame(10'h0A5, -1, -1);
        ss_n = 1'b1;
        tick();
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL rm_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rm_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] e, o;
        logic [FW-1:0] f;
        for (int n = 0; n < 4; n++) begin
            f = {2'b0, 8'($urandom_range(0, 255))};
            if (n[0]) f[8] = 1'b1;
            send_frame(f, -1, -1);
            ss_n = 1'b1;
            tick();
        end
        vectors++;
        if (obs_rx_q.size() != exp_rx_q.size()) begin
            miscompares++;
            $display("FAIL bb_count: got %0d frames, expected %0d", obs_rx_q.size(), exp_rx_q.size());
        end
        while (exp_rx_q.size() > 0 && obs_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            o = obs_rx_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL bb_frame: got %h, expected %h", o, e);
            end
        end
        exp_rx_q.delete();
        obs_rx_q.delete();
        vectors++;
        if (stray_miso != 0) begin
            miscompares++;
            $display("FAIL bb_miso_quiet: %0d high cycles, expected 0", stray_miso);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_sequence();
        test_abort();
        test_read_ordering();
        test_reset_mid_tx();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
